// File: rtl/div_unit.sv
// RV32M divide/remainder unit: 32-cycle radix-2 restoring divider
// with single-result write-back handshake.
module div_unit (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [4:0]  rd,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        flush,
    output logic        busy,
    output logic        wbValid,
    input  logic        wbReady,
    output logic [4:0]  wbAddr,
    output logic [31:0] wbData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  op_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [5:0]  cnt;

    logic        sgn_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic        sgn_q;
    logic        div_zero;
    logic        ovf;
    logic        special;
    logic [31:0] spec_res;

    logic [32:0] r_sh;
    logic [32:0] sub;
    logic        ge;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;

    logic        neg_q;
    logic        neg_r;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] fin_res;

    assign busy = (state != IDLE);

    // Operand magnitudes taken at acceptance
    assign sgn_in = ~op[0];
    assign a_mag  = (sgn_in && srcA[31]) ? -srcA : srcA;
    assign b_mag  = (sgn_in && srcB[31]) ? -srcB : srcB;

    assign sgn_q    = ~op_q[0];
    assign div_zero = (b_q == 32'd0);
    assign ovf      = sgn_q && (a_q == 32'h8000_0000)
                      && (b_q == 32'hFFFF_FFFF);
    assign special  = div_zero || ovf;

    always_comb begin
        spec_res = 32'd0;
        unique case (1'b1)
            div_zero: spec_res = op_q[1] ? a_q : 32'hFFFF_FFFF;
            ovf:      spec_res = op_q[1] ? 32'd0 : 32'h8000_0000;
            default:  spec_res = 32'd0;
        endcase
    end

    // Remainder stays below the divisor, so sub[32] is exactly the borrow
    assign r_sh   = {rem, quo[31]};
    assign sub    = r_sh - {1'b0, dvs};
    assign ge     = ~sub[32];
    assign rem_nx = ge ? sub[31:0] : r_sh[31:0];
    assign quo_nx = {quo[30:0], ge};

    assign neg_q   = sgn_q && (a_q[31] ^ b_q[31]);
    assign neg_r   = sgn_q && a_q[31];
    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;
    assign fin_res = op_q[1] ? rem_fix : quo_fix;

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            op_q    <= 2'd0;
            rd_q    <= 5'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            quo     <= 32'd0;
            rem     <= 32'd0;
            dvs     <= 32'd0;
            cnt     <= 6'd0;
            wbValid <= 1'b0;
            wbAddr  <= 5'd0;
            wbData  <= 32'd0;
        end else if (flush) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            wbValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rd_q  <= rd;
                        a_q   <= srcA;
                        b_q   <= srcB;
                        quo   <= a_mag;
                        dvs   <= b_mag;
                        rem   <= 32'd0;
                        cnt   <= 6'd0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cnt == 6'd0 && special) begin
                        wbData  <= spec_res;
                        wbAddr  <= rd_q;
                        wbValid <= 1'b1;
                        state   <= DONE;
                    end else if (cnt == 6'd32) begin
                        wbData  <= fin_res;
                        wbAddr  <= rd_q;
                        wbValid <= 1'b1;
                        cnt     <= 6'd0;
                        state   <= DONE;
                    end else begin
                        rem <= rem_nx;
                        quo <= quo_nx;
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (wbReady) begin
                        wbValid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against
// an arithmetic RV32M divide model.
module tb_div_unit;

    logic        CLK;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        flush;
    logic        busy;
    logic        wbValid;
    logic        wbReady;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;

    int total = 0;
    int bad   = 0;

    div_unit dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .rd      (rd),
        .srcA    (srcA),
        .srcB    (srcB),
        .flush   (flush),
        .busy    (busy),
        .wbValid (wbValid),
        .wbReady (wbReady),
        .wbAddr  (wbAddr),
        .wbData  (wbData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] o,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic signed [31:0] sr;
        sa = a;
        sb = b;
        if (b == 32'd0)
            return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'd0: begin sr = sa / sb; return sr; end
            2'd1: return a / b;
            2'd2: begin sr = sa % sb; return sr; end
            default: return a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] o,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r,
                         input int hold);
        int n;
        logic [31:0] exp_d;
        exp_d = ref_div(o, a, b);
        @(negedge CLK);
        start = 1'b1; op = o; srcA = a; srcB = b; rd = r;
        @(posedge CLK);
        #1;
        start = 1'b0;
        op = 2'($urandom); rd = 5'($urandom);
        srcA = $urandom; srcB = $urandom;
        check("busy_acc", 32'(busy), 32'd1);
        n = 0;
        while (!wbValid && n < 40) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("latency", n, ref_lat(o, a, b));
        check("data", wbData, exp_d);
        check("addr", 32'(wbAddr), 32'(r));
        for (int i = 0; i < hold; i++) begin
            start = 1'b1;
            srcA = $urandom; srcB = $urandom;
            @(posedge CLK);
            #1;
            check("hold_v", 32'(wbValid), 32'd1);
            check("hold_d", wbData, exp_d);
            check("hold_a", 32'(wbAddr), 32'(r));
            check("hold_b", 32'(busy), 32'd1);
        end
        start = 1'b0;
        wbReady = 1'b1;
        @(posedge CLK);
        #1;
        wbReady = 1'b0;
        check("ret_v", 32'(wbValid), 32'd0);
        check("ret_b", 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset_n = 1'b0; start = 1'b0; op = 2'd0; rd = 5'd0;
        srcA = 32'd0; srcB = 32'd0; flush = 1'b0; wbReady = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(wbValid), 32'd0);
        check("rst_data", wbData, 32'd0);
        check("rst_addr", 32'(wbAddr), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;

        do_op(2'd1, 32'd100, 32'd7, 5'd5, 0);
        do_op(2'd3, 32'd100, 32'd7, 5'd5, 0);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd1, 0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd2, 0);
        do_op(2'd1, 32'h1234_5678, 32'd0, 5'd3, 0);
        do_op(2'd3, 32'h1234_5678, 32'd0, 5'd4, 0);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 0);
        do_op(2'd0, 32'h1234_5678, 32'd0, 5'd8, 1);
        do_op(2'd1, 32'hDEAD_BEEF, 32'd13, 5'd9, 5);
        do_op(2'd1, 32'd1000, 32'd10, 5'd0, 0);

        // reset in the middle of CALC
        @(negedge CLK);
        start = 1'b1; op = 2'd1; srcA = 32'd500; srcB = 32'd3; rd = 5'd9;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (10) @(posedge CLK);
        #2 reset_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(wbValid), 32'd0);
        @(negedge CLK);
        reset_n = 1'b1;
        do_op(2'd1, 32'd9, 32'd3, 5'd10, 0);

        // flush wins over start in IDLE
        @(negedge CLK);
        flush = 1'b1; start = 1'b1;
        srcA = 32'd50; srcB = 32'd5; op = 2'd1;
        @(posedge CLK);
        #1;
        check("fl_idle", 32'(busy), 32'd0);
        flush = 1'b0; start = 1'b0;

        // flush during CALC
        @(negedge CLK);
        start = 1'b1; op = 2'd0; srcA = 32'd77; srcB = 32'd7; rd = 5'd11;
        @(posedge CLK);
        #1 start = 1'b0;
        repeat (5) @(posedge CLK);
        #1 flush = 1'b1;
        @(posedge CLK);
        #1 flush = 1'b0;
        check("fl_calc", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (wbValid) seen++;
        end
        check("fl_nowb", seen, 0);

        for (int k = 0; k < 150; k++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 20));
                3: rb = -32'($urandom_range(1, 20));
                4: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op(ro, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits and the register address width at 5 bits.
REQ-002 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin a divide operation.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-006 rd  input  5  destination register index for the result.
REQ-007 srcA  input  32  dividend, driven from the register file RD1 port.
REQ-008 srcB  input  32  divisor, driven from the register file RD2 port.
REQ-009 flush  input  1  synchronous abort of any in-flight operation.
REQ-010 busy  output  1  high whenever the unit is not idle.
REQ-011 wbValid  output  1  result available for register-file write-back.
REQ-012 wbReady  input  1  write-back port accepts the result this cycle; register-file WE = wbValid & wbReady.
REQ-013 wbAddr  output  5  destination index, drives register-file A3.
REQ-014 wbData  output  32  result, drives register-file WD3.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, CALC, DONE; busy = (state != IDLE).
REQ-016 In IDLE, start=1 and flush=0 at a rising edge E SHALL accept the operation: latch op, rd, srcA and srcB; later changes on those inputs SHALL NOT affect the result.
REQ-017 start SHALL be ignored in CALC and DONE.
REQ-018 Divisor zero: quotient = 0xFFFFFFFF and remainder = dividend, for both signed and unsigned ops; the FSM SHALL go directly to DONE with wbValid=1 from edge E+1.
REQ-019 Signed overflow (DIV/REM, srcA=0x80000000, srcB=0xFFFFFFFF): quotient = 0x80000000 and remainder = 0; the FSM SHALL go directly to DONE with wbValid=1 from edge E+1.
REQ-020 Otherwise the FSM SHALL enter CALC and run a radix-2 restoring divide on operand magnitudes (absolute values for DIV/REM, raw values for DIVU/REMU).
REQ-021 CALC SHALL perform exactly one iteration per cycle, on edges E+1..E+32, using a 6-bit iteration counter.
REQ-022 The sign fix SHALL be registered on edge E+33, where the FSM enters DONE.
REQ-023 Normal-path wbValid SHALL be 1 from edge E+33.
REQ-024 Sign rules: quotient is negated iff the operand signs differ; remainder takes the sign of the dividend; all arithmetic wraps modulo 2^32.
REQ-025 wbData SHALL carry the quotient for DIV/DIVU and the remainder for REM/REMU; wbAddr SHALL equal the latched rd.
REQ-026 In DONE, wbValid, wbData and wbAddr SHALL hold stable until wbReady=1 is sampled at a rising edge; on that edge the FSM SHALL return to IDLE with wbValid=0.
REQ-027 wbReady SHALL be ignored outside DONE.
REQ-028 rd=0 SHALL be processed normally and write back with wbAddr=0; the register file discards the write.
REQ-029 flush=1 at a rising edge SHALL force IDLE with wbValid=0, busy=0, from any state; flush SHALL win over start and wbReady in the same cycle.
REQ-030 Back-to-back operation: start may be accepted on the first edge at which the FSM is in IDLE, which is one cycle after wbReady retires the previous result.

Reset
REQ-031 reset_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE and set busy=0, wbValid=0, wbAddr=0, wbData=0, iteration counter=0.
REQ-032 Reset in CALC or DONE SHALL abort the operation with no write-back.
REQ-033 The first start is accepted on the first rising edge after reset_n returns high.

Verification
REQ-034 DIVU srcA=100, srcB=7, rd=5 accepted at E -> wbValid=1 at E+33, wbData=14, wbAddr=5; with REMU -> wbData=2.
REQ-035 DIV srcA=0xFFFFFFF9 (-7), srcB=2 -> wbData=0xFFFFFFFD (-3); REM on the same operands -> wbData=0xFFFFFFFF (-1).
REQ-036 DIVU srcA=0x12345678, srcB=0 -> wbData=0xFFFFFFFF at E+1; REMU on the same operands -> wbData=0x12345678; DIV srcA=0x80000000, srcB=0xFFFFFFFF -> wbData=0x80000000; REM on the same operands -> wbData=0.
REQ-037 Back-pressure: wbReady=0 for 5 cycles in DONE while start pulses and srcA/srcB toggle -> wbValid, wbData and wbAddr stay constant and busy stays 1; wbReady=1 -> IDLE on the next edge.
REQ-038 reset_n low at the 10th CALC cycle -> busy and wbValid drop to 0 asynchronously; after release, DIVU 9/3 -> wbData=3 at E+33.
REQ-039 flush=1 together with start=1 in IDLE -> no acceptance and busy stays 0; flush during CALC -> IDLE next edge and no wbValid pulse.
